// File: rtl/round_controller.sv
// round_controller: turn sequencer for a two-player morse guessing game.
// Player 1 enters a secret word, player 2 tries to reproduce it; a match scores,
// a mismatch costs a life. Optional P2 entry timeout is compiled in with the
// ROUND_TIMER_EN macro; without it the timer output is tied to zero and tick is unused.
module round_controller #(
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned TIME_LIMIT  = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       done_input,
  input  logic       tick,
  input  logic [9:0] p1_value,
  input  logic [9:0] p2_value,
  output logic       p1_enable,
  output logic       p2_resetn,
  output logic [9:0] code,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic [5:0] timer,
  output logic       hit,
  output logic       miss
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    P1_ENTRY  = 3'd1,
    P2_ENTRY  = 3'd2,
    CHECK     = 3'd3,
    ROUND_END = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  state_t state_q;
  logic   done_q;
  logic   done_evt;
  logic   force_miss;

  assign state    = state_q;
  assign done_evt = done_input & ~done_q;

`ifdef ROUND_TIMER_EN
  logic [5:0] timer_q;
  logic       timeout_q;
  assign timer      = timer_q;
  assign force_miss = timeout_q;
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign timer       = '0;
  assign force_miss  = 1'b0;
`endif

  // Done key edge detector; reset presets the history high so a key held
  // through reset must be seen released before it can count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) done_q <= 1'b1;
    else         done_q <= done_input;
  end

  // Round FSM with registered enables, score/lives bookkeeping and result pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      score     <= '0;
      lives     <= '0;
      code      <= '0;
      p1_enable <= 1'b0;
      p2_resetn <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
`ifdef ROUND_TIMER_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state_q)
        IDLE, GAME_OVER: begin
          if (start) begin
            score     <= '0;
            lives     <= 2'(START_LIVES);
            code      <= '0;
            state_q   <= P1_ENTRY;
            p1_enable <= 1'b1;
            p2_resetn <= 1'b0;
          end
        end
        P1_ENTRY: begin
          if (done_evt && (p1_value != '0)) begin
            code      <= p1_value;
            state_q   <= P2_ENTRY;
            p1_enable <= 1'b0;
            p2_resetn <= 1'b1;
`ifdef ROUND_TIMER_EN
            timer_q   <= 6'(TIME_LIMIT);
            timeout_q <= 1'b0;
`endif
          end
        end
        P2_ENTRY: begin
          if (done_evt) begin
            state_q   <= CHECK;
            p2_resetn <= 1'b0;
`ifdef ROUND_TIMER_EN
            timeout_q <= 1'b0;
          end else if (tick) begin
            // Expiry is judged on the pre-decrement value so a done in the
            // same cycle (handled above) still wins.
            timer_q <= timer_q - 6'd1;
            if (timer_q <= 6'd1) begin
              state_q   <= CHECK;
              p2_resetn <= 1'b0;
              timeout_q <= 1'b1;
            end
`endif
          end
        end
        CHECK: begin
          if (!force_miss && (p2_value == code)) begin
            hit     <= 1'b1;
            state_q <= ROUND_END;
            if (score != 4'd15) score <= score + 4'd1;
          end else begin
            miss <= 1'b1;
            if (lives <= 2'd1) begin
              lives   <= '0;
              state_q <= GAME_OVER;
            end else begin
              lives   <= lives - 2'd1;
              state_q <= ROUND_END;
            end
          end
        end
        ROUND_END: begin
          state_q   <= P1_ENTRY;
          p1_enable <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          p1_enable <= 1'b0;
          p2_resetn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed self-checking bench for round_controller; covers the optional
// timeout feature when ROUND_TIMER_EN is defined for the build.
module tb_round_controller;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic       done_input = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] p1_value = '0;
  logic [9:0] p2_value = '0;
  logic       p1_enable, p2_resetn, hit, miss;
  logic [9:0] code;
  logic [3:0] score;
  logic [1:0] lives;
  logic [2:0] state;
  logic [5:0] timer;

  int checks = 0;
  int failures = 0;

  round_controller #(.START_LIVES(3), .TIME_LIMIT(3)) dut (
    .clock(clock), .resetn(resetn), .start(start), .done_input(done_input),
    .tick(tick), .p1_value(p1_value), .p2_value(p2_value),
    .p1_enable(p1_enable), .p2_resetn(p2_resetn), .code(code),
    .score(score), .lives(lives), .state(state), .timer(timer),
    .hit(hit), .miss(miss)
  );

  always #5 clock = ~clock;

  task automatic clk1();
    @(posedge clock);
    #1;
  endtask

  // Full round from P1_ENTRY; returns one cycle after CHECK so hit/miss are visible.
  task automatic play_round(input logic [9:0] a, input logic [9:0] b);
    p1_value = a; done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
    p2_value = b; done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({score, lives, code, timer} !== 22'd0) begin failures++; $display("FAIL reset_regs got=%h exp=0", {score, lives, code, timer}); end
    checks++; if ({p1_enable, p2_resetn, hit, miss} !== 4'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {p1_enable, p2_resetn, hit, miss}); end
    clk1(); clk1();
    resetn = 1'b1;
    clk1();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
  endtask

  task automatic test_single_hit();
    start = 1'b1; clk1(); start = 1'b0;
    checks++; if (state !== 3'd1 || p1_enable !== 1'b1) begin failures++; $display("FAIL start_p1 got=%0d/%b exp=1/1", state, p1_enable); end
    checks++; if (lives !== 2'd3 || score !== 4'd0) begin failures++; $display("FAIL start_load got=%0d/%0d exp=3/0", lives, score); end
    p1_value = 10'b0000000111; done_input = 1'b1; clk1(); done_input = 1'b0;
    checks++; if (state !== 3'd2 || code !== 10'h007) begin failures++; $display("FAIL p1_latch got=%0d/%h exp=2/007", state, code); end
    checks++; if (p2_resetn !== 1'b1 || p1_enable !== 1'b0) begin failures++; $display("FAIL p2_enables got=%b/%b exp=1/0", p2_resetn, p1_enable); end
    clk1();
    p2_value = 10'b0000000111; done_input = 1'b1; clk1(); done_input = 1'b0;
    checks++; if (state !== 3'd3 || p2_resetn !== 1'b0) begin failures++; $display("FAIL check_state got=%0d/%b exp=3/0", state, p2_resetn); end
    clk1();
    checks++; if (hit !== 1'b1 || miss !== 1'b0) begin failures++; $display("FAIL hit_pulse got=%b%b exp=10", hit, miss); end
    checks++; if (score !== 4'd1 || lives !== 2'd3 || state !== 3'd4) begin failures++; $display("FAIL after_hit got=%0d/%0d/%0d exp=1/3/4", score, lives, state); end
    clk1();
    checks++; if (state !== 3'd1 || hit !== 1'b0 || p1_enable !== 1'b1) begin failures++; $display("FAIL back_p1 got=%0d/%b/%b exp=1/0/1", state, hit, p1_enable); end
  endtask

  task automatic test_game_over();
    for (int k = 1; k <= 3; k++) begin
      play_round(10'h007, 10'h00D);
      checks++; if (miss !== 1'b1 || hit !== 1'b0) begin failures++; $display("FAIL miss_pulse%0d got=%b%b exp=01", k, hit, miss); end
      checks++; if (lives !== 2'(3 - k)) begin failures++; $display("FAIL lives%0d got=%0d exp=%0d", k, lives, 3 - k); end
      checks++; if (state !== ((k == 3) ? 3'd5 : 3'd4)) begin failures++; $display("FAIL miss_state%0d got=%0d exp=%0d", k, state, (k == 3) ? 5 : 4); end
      if (k < 3) clk1();
    end
    clk1(); clk1(); clk1();
    checks++; if (state !== 3'd5 || score !== 4'd1 || lives !== 2'd0 || code !== 10'h007) begin failures++; $display("FAIL go_hold got=%0d/%0d/%0d/%h exp=5/1/0/007", state, score, lives, code); end
    checks++; if (miss !== 1'b0 || p1_enable !== 1'b0) begin failures++; $display("FAIL go_quiet got=%b/%b exp=0/0", miss, p1_enable); end
    start = 1'b1; clk1(); start = 1'b0;
    checks++; if (state !== 3'd1 || score !== 4'd0 || lives !== 2'd3 || code !== 10'h000) begin failures++; $display("FAIL restart got=%0d/%0d/%0d/%h exp=1/0/3/000", state, score, lives, code); end
  endtask

  task automatic test_zero_word();
    p1_value = '0; done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
    checks++; if (state !== 3'd1 || code !== 10'h000) begin failures++; $display("FAIL zero_word got=%0d/%h exp=1/000", state, code); end
    start = 1'b1; clk1(); start = 1'b0;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_ignored_p1 got=%0d exp=1", state); end
    p1_value = 10'h007; done_input = 1'b1; clk1();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL held_enter got=%0d exp=2", state); end
    start = 1'b1;
    for (int i = 0; i < 19; i++) clk1();
    start = 1'b0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL held_single got=%0d exp=2", state); end
    done_input = 1'b0; clk1();
    p2_value = 10'h007; done_input = 1'b1; clk1(); done_input = 1'b0;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL held_release got=%0d exp=3", state); end
    clk1();
    checks++; if (hit !== 1'b1 || score !== 4'd1) begin failures++; $display("FAIL held_hit got=%b/%0d exp=1/1", hit, score); end
    clk1();
  endtask

  task automatic test_timer();
`ifdef ROUND_TIMER_EN
    p1_value = 10'h007; done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
    checks++; if (state !== 3'd2 || timer !== 6'd3) begin failures++; $display("FAIL timer_load got=%0d/%0d exp=2/3", state, timer); end
    for (int e = 2; e >= 1; e--) begin
      tick = 1'b1; clk1(); tick = 1'b0;
      checks++; if (timer !== 6'(e) || state !== 3'd2) begin failures++; $display("FAIL timer_dec got=%0d/%0d exp=%0d/2", timer, state, e); end
    end
    tick = 1'b1; clk1(); tick = 1'b0;
    checks++; if (timer !== 6'd0 || state !== 3'd3) begin failures++; $display("FAIL timer_expire got=%0d/%0d exp=0/3", timer, state); end
    clk1();
    checks++; if (miss !== 1'b1 || hit !== 1'b0 || lives !== 2'd2) begin failures++; $display("FAIL timeout_miss got=%b%b/%0d exp=01/2", hit, miss, lives); end
    clk1();
    p1_value = 10'h007; done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
    tick = 1'b1; clk1(); clk1();
    done_input = 1'b1; clk1(); tick = 1'b0; done_input = 1'b0;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL race_check got=%0d exp=3", state); end
    clk1();
    checks++; if (hit !== 1'b1 || miss !== 1'b0) begin failures++; $display("FAIL race_hit got=%b%b exp=10", hit, miss); end
    clk1();
`else
    p1_value = 10'h007; done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
    tick = 1'b1;
    for (int i = 0; i < 5; i++) clk1();
    tick = 1'b0;
    checks++; if (state !== 3'd2 || timer !== 6'd0) begin failures++; $display("FAIL no_timer got=%0d/%0d exp=2/0", state, timer); end
    done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
    checks++; if (hit !== 1'b1 || score !== 4'd2) begin failures++; $display("FAIL no_timer_hit got=%b/%0d exp=1/2", hit, score); end
    clk1();
`endif
  endtask

  task automatic test_mid_reset();
    p1_value = 10'h007; done_input = 1'b1; clk1(); done_input = 1'b0; clk1();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL mid_setup got=%0d exp=2", state); end
    resetn = 1'b0; #1;
    checks++; if (state !== 3'd0 || p2_resetn !== 1'b0 || score !== 4'd0 || code !== 10'h000) begin failures++; $display("FAIL mid_reset got=%0d/%b/%0d/%h exp=0/0/0/000", state, p2_resetn, score, code); end
    done_input = 1'b1; clk1();
    resetn = 1'b1; start = 1'b1; clk1(); start = 1'b0;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL post_reset_start got=%0d exp=1", state); end
    clk1();
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL held_through_reset got=%0d exp=1", state); end
    done_input = 1'b0; clk1(); done_input = 1'b1; clk1(); done_input = 1'b0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL first_event got=%0d exp=2", state); end
    clk1();
  endtask

  task automatic test_saturation();
    resetn = 1'b0; #1; resetn = 1'b1;
    start = 1'b1; clk1(); start = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      play_round(10'h3FF, 10'h3FF);
      if (r >= 15) begin
        checks++; if (hit !== 1'b1 || score !== 4'd15) begin failures++; $display("FAIL sat%0d got=%b/%0d exp=1/15", r, hit, score); end
      end
      clk1();
    end
    checks++; if (state !== 3'd1 || lives !== 2'd3) begin failures++; $display("FAIL sat_end got=%0d/%0d exp=1/3", state, lives); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_game_over();
    test_zero_word();
    test_timer();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 The block SHALL have parameter START_LIVES, default 3, setting lives loaded at game start (1..3).
REQ-002 The block SHALL have parameter TIME_LIMIT, default 30, setting player-2 entry time in tick units (1..63).
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, new-game request, level-sampled.
REQ-006 The block SHALL have port done_input, input, 1, player "finished" key, level; the block edge-detects it internally.
REQ-007 The block SHALL have port tick, input, 1, one-cycle timebase enable pulse.
REQ-008 The block SHALL have port p1_value, input, 10, player-1 encoded morse word (2 bits/symbol: 01 dot, 11 line).
REQ-009 The block SHALL have port p2_value, input, 10, player-2 encoded morse word, same encoding.
REQ-010 The block SHALL have port p1_enable, output, 1, high while player 1 may enter.
REQ-011 The block SHALL have port p2_resetn, output, 1, active-low clear for the player-2 entry datapath.
REQ-012 The block SHALL have port code, output, 10, latched secret word.
REQ-013 The block SHALL have ports score, output, 4, and lives, output, 2.
REQ-014 The block SHALL have ports state, output, 3; timer, output, 6; hit and miss, output, 1 each (one-cycle pulses).

Function
REQ-015 States SHALL be IDLE=0, P1_ENTRY=1, P2_ENTRY=2, CHECK=3, ROUND_END=4, GAME_OVER=5, driven on state.
REQ-016 A done event SHALL be a 0->1 transition of done_input between consecutive clock edges; holding it high yields one event.
REQ-017 IDLE or GAME_OVER with start=1 SHALL load score=0, lives=START_LIVES, clear code, and enter P1_ENTRY next cycle; start SHALL be ignored in all other states.
REQ-018 In P1_ENTRY, p1_enable SHALL be 1; a done event with p1_value!=0 SHALL latch code<=p1_value and enter P2_ENTRY; a done event with p1_value==0 SHALL be ignored.
REQ-019 p2_resetn SHALL be registered and equal 1 only while state is P2_ENTRY, so player-2 entry starts empty each round.
REQ-020 In P2_ENTRY, a done event SHALL enter CHECK.
REQ-021 CHECK SHALL last exactly one cycle: p2_value==code pulses hit and increments score, saturating at 15; otherwise pulses miss and decrements lives.
REQ-022 From CHECK, lives reaching 0 SHALL enter GAME_OVER; otherwise ROUND_END.
REQ-023 ROUND_END SHALL last one cycle and return to P1_ENTRY.
REQ-024 GAME_OVER SHALL hold score, lives=0 and code until start.
REQ-025 hit and miss SHALL never assert in the same cycle and SHALL be 0 outside the cycle after CHECK evaluation.
REQ-026 Undefined state encodings 6-7 SHALL return to IDLE on the next edge.

Reset
REQ-027 resetn=0 SHALL immediately force state=IDLE, score=0, lives=0, code=0, timer=0, p1_enable=0, p2_resetn=0, hit=0, miss=0, and clear the done edge detector, including mid-round.
REQ-028 After release, the first done event SHALL require done_input to be sampled low at least once.

Configuration
REQ-029 With macro ROUND_TIMER_EN defined, timer SHALL load TIME_LIMIT on entry to P2_ENTRY, decrement on each tick in P2_ENTRY, and on reaching 0 force CHECK with a miss regardless of p2_value.
REQ-030 With ROUND_TIMER_EN defined, a done event in the same cycle as expiry SHALL take precedence, giving a normal comparison.
REQ-031 Without ROUND_TIMER_EN, timer SHALL be constant 0, tick SHALL be ignored, and P2_ENTRY SHALL exit only on a done event.

Verification
REQ-032 Reset; start=1; p1_value=10'b0000000111; done; p2_value same; done -> hit pulse, score=1, lives=3, state back to 1.
REQ-033 Three rounds with p2_value mismatched -> miss x3, lives 3->2->1->0, state=5; start -> score=0, lives=3, state=1.
REQ-034 Done with p1_value=0 in P1_ENTRY -> state stays 1, code unchanged; done_input held high 20 cycles -> single transition only.
REQ-035 ROUND_TIMER_EN, TIME_LIMIT=3, three ticks in P2_ENTRY, no done -> timer 3,2,1,0, miss pulse, lives-1.
REQ-036 resetn low during P2_ENTRY -> state=0, p2_resetn=0, score=0 asynchronously; 16 hits -> score saturates at 15.
